// File: rtl/hilo_mul_ctrl.sv
// ---------------------------------------------------------------------------
// hilo_mul_ctrl
//
// Multi-cycle sequencer for the HI/LO unit of the execute stage. It accepts
// MULT/MULTU/MTHI/MTLO (and MADD/MADDU when HILO_MADD_EN is defined) from
// decode. For a product it registers the operands and holds the external
// combinational multiplier enabled for MUL_LAT cycles. It then captures the
// 64-bit result into the architectural HI/LO registers. Decode is stalled
// through busy while a product is in flight. flush squashes any in-flight
// operation.
//
// Optional feature macro: HILO_MADD_EN (MADD/MADDU accumulate into HI/LO).
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   flush        abort in-flight op, drop same-cycle issue
//   issue_valid  operation offered this cycle
//   issue_op     3-bit opcode (MULT/MULTU/MTHI/MTLO/MADD/MADDU)
//   issue_rs     first operand / MTHI/MTLO source
//   issue_rt     second operand
//   issue_ready  high when an offered issue is accepted this cycle
//   busy         product in flight, decode must stall
//   done         one-cycle pulse after HI/LO updated by a product
//   mul_ena      multiplier enable
//   mul_sign     1 signed, 0 unsigned
//   mul_a/mul_b  registered multiplier operands
//   mul_hi/lo    multiplier result
//   hi/lo        architectural HI/LO
// ---------------------------------------------------------------------------
module hilo_mul_ctrl #(
    parameter int MUL_LAT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        issue_valid,
    input  logic [2:0]  issue_op,
    input  logic [31:0] issue_rs,
    input  logic [31:0] issue_rt,
    output logic        issue_ready,
    output logic        busy,
    output logic        done,
    output logic        mul_ena,
    output logic        mul_sign,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [31:0] mul_hi,
    input  logic [31:0] mul_lo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_MTHI  = 3'b010;
    localparam logic [2:0] OP_MTLO  = 3'b011;
`ifdef HILO_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MADDU = 3'b101;
`endif

    // Counter preload: WAIT lasts MUL_LAT cycles, capture happens when cnt hits 0.
    localparam logic [3:0] CNT_LOAD = 4'(MUL_LAT - 1);

    logic [0:0]  state_r,    state_s;
    logic [3:0]  cnt_r,      cnt_s;
    logic [31:0] hi_r,       hi_s;
    logic [31:0] lo_r,       lo_s;
    logic [31:0] mul_a_r,    mul_a_s;
    logic [31:0] mul_b_r,    mul_b_s;
    logic        mul_sign_r, mul_sign_s;
    logic        done_r,     done_s;
    logic        busy_r,     busy_s;
    logic        ena_r;
    logic        ready_r,    ready_s;
`ifdef HILO_MADD_EN
    logic        acc_r,      acc_s;

    // 64-bit HI/LO accumulate; carry from lo into hi, wraps mod 2^64.
    function automatic logic [63:0] hilo_accum(input logic [63:0] cur,
                                               input logic [63:0] prod);
        return cur + prod;
    endfunction
`endif

    // Next-state and datapath decode for the IDLE/WAIT sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        hi_s       = hi_r;
        lo_s       = lo_r;
        mul_a_s    = mul_a_r;
        mul_b_s    = mul_b_r;
        mul_sign_s = mul_sign_r;
        done_s     = 1'b0;
`ifdef HILO_MADD_EN
        acc_s      = acc_r;
`endif
        if (flush) begin
            // Squash: drop whatever is in flight and any same-cycle issue.
            state_s = ST_IDLE;
            cnt_s   = 4'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (issue_valid) begin
                        case (issue_op)
                            OP_MULT, OP_MULTU: begin
                                mul_a_s    = issue_rs;
                                mul_b_s    = issue_rt;
                                mul_sign_s = (issue_op == OP_MULT);
`ifdef HILO_MADD_EN
                                acc_s      = 1'b0;
`endif
                                cnt_s      = CNT_LOAD;
                                state_s    = ST_WAIT;
                            end
`ifdef HILO_MADD_EN
                            OP_MADD, OP_MADDU: begin
                                mul_a_s    = issue_rs;
                                mul_b_s    = issue_rt;
                                mul_sign_s = (issue_op == OP_MADD);
                                acc_s      = 1'b1;
                                cnt_s      = CNT_LOAD;
                                state_s    = ST_WAIT;
                            end
`endif
                            OP_MTHI: begin
                                hi_s = issue_rs;
                            end
                            OP_MTLO: begin
                                lo_s = issue_rs;
                            end
                            default: begin
                                // Reserved opcode: silently ignored.
                                state_s = ST_IDLE;
                            end
                        endcase
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_s = cnt_r - 4'd1;
                    end else begin
`ifdef HILO_MADD_EN
                        if (acc_r) begin
                            {hi_s, lo_s} = hilo_accum({hi_r, lo_r}, {mul_hi, mul_lo});
                        end else begin
                            {hi_s, lo_s} = {mul_hi, mul_lo};
                        end
`else
                        {hi_s, lo_s} = {mul_hi, mul_lo};
`endif
                        done_s  = 1'b1;
                        state_s = ST_IDLE;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                    cnt_s   = 4'd0;
                end
            endcase
        end
        // Handshake outputs are registered copies of the next-state decode.
        busy_s  = (state_s == ST_WAIT);
        ready_s = (state_s == ST_IDLE);
    end

    // State, counter, HI/LO, operand and handshake registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= 4'd0;
            hi_r       <= 32'd0;
            lo_r       <= 32'd0;
            mul_a_r    <= 32'd0;
            mul_b_r    <= 32'd0;
            mul_sign_r <= 1'b0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            ena_r      <= 1'b0;
            ready_r    <= 1'b1;
`ifdef HILO_MADD_EN
            acc_r      <= 1'b0;
`endif
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            hi_r       <= hi_s;
            lo_r       <= lo_s;
            mul_a_r    <= mul_a_s;
            mul_b_r    <= mul_b_s;
            mul_sign_r <= mul_sign_s;
            done_r     <= done_s;
            busy_r     <= busy_s;
            ena_r      <= busy_s;
            ready_r    <= ready_s;
`ifdef HILO_MADD_EN
            acc_r      <= acc_s;
`endif
        end
    end

    assign issue_ready = ready_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign mul_ena     = ena_r;
    assign mul_sign    = mul_sign_r;
    assign mul_a       = mul_a_r;
    assign mul_b       = mul_b_r;
    assign hi          = hi_r;
    assign lo          = lo_r;

endmodule

// File: doc/hilo_mul_ctrl.md
# hilo_mul_ctrl

Multi-cycle sequencer for the HI/LO unit of the execute stage. Accepts MULT/MULTU/MTHI/MTLO from decode, drives the combinational multiplier with registered operands for a fixed multicycle budget, then captures its 64-bit result into the architectural HI/LO registers. Stalls the pipeline while a product is in flight, and supports squash on branch/exception flush.

## Interface
- MUL_LAT, 4: cycles the multiplier inputs are held stable before capture; legal range 1..15.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  abort in-flight operation; drop same-cycle issue
- issue_valid  in  1  operation offered this cycle
- issue_op  in  3  000 MULT, 001 MULTU, 010 MTHI, 011 MTLO, 100 MADD, 101 MADDU, others reserved
- issue_rs  in  32  first operand / MTHI/MTLO source
- issue_rt  in  32  second operand
- issue_ready  out  1  high when an issue is accepted this cycle
- busy  out  1  product in flight; decode must stall
- done  out  1  one-cycle pulse, HI/LO just updated by a product
- mul_ena  out  1  multiplier enable
- mul_sign  out  1  1 signed, 0 unsigned
- mul_a, mul_b  out  32  registered multiplier operands
- mul_hi, mul_lo  in  32  multiplier result
- hi, lo  out  32  architectural HI/LO

## Operation
- States: IDLE, WAIT.
- IDLE: issue_ready=1, busy=0, mul_ena=0.
- IDLE + issue_valid + MULT/MULTU (or MADD/MADDU when enabled):
  - latch rs→mul_a, rt→mul_b, op signedness→mul_sign, accumulate flag;
  - load cnt=MUL_LAT-1;
  - go to WAIT.
- IDLE + issue_valid + MTHI: hi←rs. MTLO: lo←rs. State stays IDLE, no done.
- Reserved opcodes are ignored: no state change, registers unchanged.
- WAIT: mul_ena=1, busy=1, issue_ready=0.
  - cnt≠0: decrement.
  - cnt==0: {hi,lo}←{mul_hi,mul_lo} (or {hi,lo}+{mul_hi,mul_lo} mod 2^64 when accumulating); done←1; go to IDLE.
- issue_valid while in WAIT is ignored. The producer must hold the request until issue_ready.
- flush (any state): next state IDLE, cnt cleared, done=0, hi/lo unchanged. A same-cycle issue is dropped, MTHI/MTLO included.
- mul_a/mul_b/mul_sign hold their last values in IDLE.

## Timing
- Reset values: hi=0, lo=0, mul_a=0, mul_b=0, mul_sign=0, done=0, busy=0, mul_ena=0, issue_ready=1, state IDLE, cnt=0.
- Product issue accepted at edge E0:
  - mul_ena/busy high from E0 to E(MUL_LAT);
  - hi/lo capture at E(MUL_LAT);
  - done high exactly one cycle after E(MUL_LAT), while issue_ready is already 1.
- Next product issue is accepted at E(MUL_LAT+1) at the earliest, giving a throughput of one per MUL_LAT+1 cycles.
- MTHI/MTLO take effect at the accepting edge, so the new value is visible the next cycle.
- MUL_LAT=1: accept at E0, capture at E1.
- reset dominates flush and issue. flush dominates capture: flush at the capture cycle means no update and no done.
- mul_hi/mul_lo are sampled only at the capture edge. They must be valid MUL_LAT cycles after mul_a/mul_b change.

## Configuration
- HILO_MADD_EN defined:
  - opcodes 100/101 accepted as MADD/MADDU;
  - the product is added to the current {hi,lo} at capture, with carry from lo into hi and wrap mod 2^64.
- HILO_MADD_EN undefined: opcodes 100/101 are reserved and ignored, and no 64-bit adder is synthesized.

## Test plan
- Reset: assert reset 2 cycles mid-WAIT → hi=lo=0, busy=0, issue_ready=1, done=0 next cycle.
- MULTU 0xFFFFFFFF×0xFFFFFFFF, MUL_LAT=4:
  - busy exactly 4 cycles;
  - then hi=0xFFFFFFFE, lo=0x00000001;
  - done pulses once.
- MULT 0xFFFFFFFD×0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. Issue offered during WAIT is ignored and then accepted when ready.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 in consecutive cycles → hi=0x12345678, lo=0x9ABCDEF0, busy never set, no done.
- MULTU 5×6 with flush on 2nd WAIT cycle → hi/lo keep prior values, no done, issue_ready=1 next cycle. Flush concurrent with MTHI → hi unchanged.
- With HILO_MADD_EN, hi=0, lo=0xFFFFFFFF: MADDU 1×1 → hi=0x00000001, lo=0x00000000. Without the macro, same stimulus → hi/lo unchanged, busy never set.
